hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
// Pipeline control master that drives the en/flush pair of every pipeline register
// (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC write enable. It sits beside the datapath.
// It watches ID/EX and EX/MEM control bits and cache hits, and decides freeze, bubble,
// redirect flush and halt. It also keeps saturating stall/flush event counters.
// PARAMETERS
// CNT_W  32  width of stall_cnt and flush_cnt
// RW     5   register-index width
// PORTS
// CLK          in   1      clock, rising edge
// nRST         in   1      asynchronous active-low reset
// ihit         in   1      instruction fetch complete this cycle
// dhit         in   1      data access complete this cycle
// ifid_rs      in   RW     rs of instruction in IF/ID
// ifid_rt      in   RW     rt of instruction in IF/ID
// idex_dREN    in   1      ID/EX holds a load
// idex_rt      in   RW     load destination in ID/EX
// exmem_dREN   in   1      EX/MEM holds a load
// exmem_dWEN   in   1      EX/MEM holds a store
// redirect     in   1      EX/MEM resolved taken branch/jump (PC gets target)
// memwb_halt   in   1      halt reached MEM/WB
// pc_en        out  1      PC register write enable
// ifid_en, idex_en, exmem_en, memwb_en           out 1 each  register advance
// ifid_flush, idex_flush, exmem_flush, memwb_flush out 1 each register clear
// halt         out  1      sticky halt to system
// stall_cnt    out  CNT_W  cycles with pc_en=0 while not HALTED, saturating
// flush_cnt    out  CNT_W  redirect events accepted, saturating
// BEHAVIOUR
// - Reset (async, nRST=0): state=RUN, all en/flush/pc_en=0, halt=0, counters=0.
// - States: RUN, REDIR (redirect accepted, waiting for target fetch), HALTED.
// - Outputs are combinational from state and inputs. Evaluate in priority order; first match wins:
//   1 HALTED: all en=0, flush=0, pc_en=0, halt=1. Only reset leaves HALTED.
//   2 memwb_halt=1: next state=HALTED. This cycle all en=0, pc_en=0.
//   3 mem wait ((exmem_dREN|exmem_dWEN) & !dhit): full freeze. All en=0, all flush=0, pc_en=0.
//   4 redirect=1 (RUN): pc_en=1; ifid_flush=idex_flush=exmem_flush=1; memwb_en=1.
//     Next state=REDIR if !ihit, else stays RUN. flush_cnt +1.
//   5 REDIR: ifid_flush=1, idex_flush=1, exmem_en=memwb_en=1, pc_en=ihit.
//     On ihit: next state=RUN.
//   6 load-use (idex_dREN & idex_rt!=0 & (idex_rt==ifid_rs | idex_rt==ifid_rt)):
//     pc_en=0, ifid_en=0, idex_flush=1, exmem_en=memwb_en=1. One bubble only.
//   7 fetch wait (!ihit): pc_en=0, ifid_en=0, idex_flush=1, exmem_en=memwb_en=1.
//   8 normal: pc_en=1, all en=1, all flush=0.
// - A flush of a register overrides its en. en and flush are never both 1 for the same register.
// - Simultaneous events: a memory wait defers a redirect until dhit, with state held.
//   Redirect beats load-use, because the loaded instruction is squashed anyway.
// - Counters: stall_cnt increments on each cycle with pc_en=0 in RUN/REDIR.
//   Both counters saturate at all-ones, with no wrap.
// - Reset mid-REDIR or in HALTED returns to RUN with outputs as at reset.
//   The first cycle after reset release follows the normal rules.
// TESTING
// - Reset then ihit=1, no hazards -> pc_en=1, all en=1 every cycle; stall_cnt=0.
// - idex_dREN=1, idex_rt=8, ifid_rs=8 -> one cycle with pc_en=0, ifid_en=0, idex_flush=1;
//   idex_rt=0 with ifid_rs=0 -> no stall.
// - exmem_dREN=1, dhit low 3 cycles -> all en=0 for 3 cycles, stall_cnt=3; dhit=1 -> normal.
// - redirect=1 with ihit=0 for 2 cycles -> REDIR. ifid_flush/idex_flush held until ihit.
//   flush_cnt=1.
// - redirect=1 while exmem_dWEN=1, dhit=0 -> frozen, no flush. Flush happens on the dhit cycle.
// - memwb_halt=1 -> halt=1 sticky and all en=0. Assert nRST=0 mid-HALTED -> all outputs 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline freeze/bubble/flush/halt control with saturating stall and flush counters.
module hazard_ctrl #(
    parameter int CNT_W = 32,
    parameter int RW    = 5
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic [RW-1:0]    ifid_rs,
    input  logic [RW-1:0]    ifid_rt,
    input  logic             idex_dREN,
    input  logic [RW-1:0]    idex_rt,
    input  logic             exmem_dREN,
    input  logic             exmem_dWEN,
    input  logic             redirect,
    input  logic             memwb_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    typedef enum logic [1:0] {RUN, REDIR, HALTED} state_t;
    state_t state, next_state;
    logic mem_wait, load_use, flush_ev;
    // {pc_en, ifid/idex/exmem/memwb en, ifid/idex/exmem/memwb flush}
    logic [8:0] ctl;

    assign mem_wait = (exmem_dREN | exmem_dWEN) & ~dhit;
    assign load_use = idex_dREN & (idex_rt != '0) & ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            state <= RUN;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (state == HALTED)
            next_state = HALTED;
        else if (memwb_halt)
            next_state = HALTED;
        else if (mem_wait)
            next_state = state;
        else if (state == RUN && redirect)
            next_state = ihit ? RUN : REDIR;
        else if (state == REDIR && ihit)
            next_state = RUN;
    end

    always_comb begin
        ctl = '0;
        flush_ev = 1'b0;
        if (state == HALTED || memwb_halt || mem_wait)
            ctl = '0;
        else if (state == RUN && redirect) begin
            ctl = 9'b1_0001_1110;
            flush_ev = 1'b1;
        end
        else if (state == REDIR)
            ctl = {ihit, 8'b0011_1100};
        else if (load_use || !ihit)
            ctl = 9'b0_0011_0100;
        else
            ctl = 9'b1_1111_0000;
    end

    // outputs read as zero while reset is held, whatever the inputs do
    assign {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
            ifid_flush, idex_flush, exmem_flush, memwb_flush} = nRST ? ctl : 9'b0;
    assign halt = nRST & (state == HALTED);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (state != HALTED && !ctl[8] && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (flush_ev && flush_cnt != '1)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and randomized checks of hazard_ctrl against a rule-level reference model.
module tb_hazard_ctrl;
    localparam int CW = 4;
    localparam int SAT = (1 << CW) - 1;

    logic CLK = 0, nRST = 0;
    logic ihit = 0, dhit = 0, idex_dREN = 0, exmem_dREN = 0, exmem_dWEN = 0, redirect = 0, memwb_halt = 0;
    logic [4:0] ifid_rs = 0, ifid_rt = 0, idex_rt = 0;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush, exmem_flush, memwb_flush, halt;
    logic [CW-1:0] stall_cnt, flush_cnt;

    hazard_ctrl #(.CNT_W(CW), .RW(5)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .idex_dREN(idex_dREN), .idex_rt(idex_rt), .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN),
        .redirect(redirect), .memwb_halt(memwb_halt), .pc_en(pc_en), .ifid_en(ifid_en),
        .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
        .halt(halt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 CLK = ~CLK;

    int errors = 0, checks = 0;
    bit m_halted = 0, m_redir = 0;
    int m_stall = 0, m_flush = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [31:0] got_ctl();
        return {21'b0, halt, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                ifid_flush, idex_flush, exmem_flush, memwb_flush};
    endfunction

    // One cycle: inputs were set at the falling edge; predict, compare, advance the model.
    task automatic tick();
        bit e_halt = 0, e_pc = 0, flush_ev = 0, n_halted, n_redir;
        bit [3:0] e_en = 0, e_fl = 0;
        bit mw, lu;
        n_halted = m_halted;
        n_redir = m_redir;
        mw = (exmem_dREN || exmem_dWEN) && !dhit;
        lu = idex_dREN && idex_rt != 0 && (idex_rt == ifid_rs || idex_rt == ifid_rt);
        if (m_halted) e_halt = 1;
        else if (memwb_halt) n_halted = 1;
        else if (mw) ;
        else if (redirect && !m_redir) begin
            e_pc = 1; e_en = 4'b0001; e_fl = 4'b1110; flush_ev = 1; n_redir = !ihit;
        end
        else if (m_redir) begin
            e_pc = ihit; e_en = 4'b0011; e_fl = 4'b1100; if (ihit) n_redir = 0;
        end
        else if (lu || !ihit) begin
            e_en = 4'b0011; e_fl = 4'b0100;
        end
        else begin
            e_pc = 1; e_en = 4'b1111;
        end
        #1;
        check("ctl", got_ctl(), {21'b0, e_halt, e_pc, e_en, e_fl});
        check("en_flush_excl", 32'({ifid_en, idex_en, exmem_en, memwb_en} &
                                   {ifid_flush, idex_flush, exmem_flush, memwb_flush}), 0);
        check("stall_cnt", 32'(stall_cnt), 32'(m_stall < SAT ? m_stall : SAT));
        check("flush_cnt", 32'(flush_cnt), 32'(m_flush < SAT ? m_flush : SAT));
        @(posedge CLK);
        if (!m_halted && !e_pc) m_stall++;
        if (flush_ev) m_flush++;
        m_halted = n_halted;
        m_redir = n_redir;
        @(negedge CLK);
    endtask

    task automatic idle();
        ihit = 1; dhit = 1; idex_dREN = 0; exmem_dREN = 0; exmem_dWEN = 0;
        redirect = 0; memwb_halt = 0; ifid_rs = 0; ifid_rt = 0; idex_rt = 0;
    endtask

    // Async reset asserted mid-cycle; outputs and counters must drop at once.
    task automatic do_reset();
        #3 nRST = 0;
        #1;
        check("rst_ctl", got_ctl(), 0);
        check("rst_cnt", 32'({stall_cnt, flush_cnt}), 0);
        m_halted = 0; m_redir = 0; m_stall = 0; m_flush = 0;
        @(negedge CLK);
        nRST = 1;
    endtask

    initial begin
        idle();
        @(negedge CLK);
        do_reset();
        repeat (4) tick();
        idex_dREN = 1; idex_rt = 8; ifid_rs = 8; tick();
        idex_dREN = 0; tick();
        idex_dREN = 1; idex_rt = 0; ifid_rs = 0; tick();
        idle(); exmem_dREN = 1; dhit = 0; repeat (3) tick();
        check("stall_after_memwait", 32'(stall_cnt), 4);
        dhit = 1; tick();
        idle(); redirect = 1; ihit = 0; tick();
        redirect = 0; repeat (2) tick();
        ihit = 1; tick(); tick();
        exmem_dWEN = 1; dhit = 0; redirect = 1; repeat (2) tick();
        dhit = 1; tick();
        idle(); tick();
        memwb_halt = 1; tick();
        memwb_halt = 0; repeat (3) tick();
        do_reset();
        idle(); tick();
        redirect = 1; ihit = 0; tick();
        redirect = 0; tick();
        do_reset();
        idle(); ihit = 0; repeat (20) tick();
        ihit = 1; redirect = 1; repeat (18) tick();
        idle(); tick();
        do_reset();
        for (int i = 0; i < 800; i++) begin
            ihit = $urandom_range(3) != 0;
            dhit = $urandom_range(3) != 0;
            exmem_dREN = $urandom_range(3) == 0;
            exmem_dWEN = !exmem_dREN && $urandom_range(4) == 0;
            idex_dREN = $urandom_range(2) == 0;
            idex_rt = 5'($urandom_range(3));
            ifid_rs = 5'($urandom_range(3));
            ifid_rt = 5'($urandom_range(3));
            redirect = $urandom_range(6) == 0;
            memwb_halt = $urandom_range(60) == 0;
            if ($urandom_range(80) == 0 || (m_halted && $urandom_range(5) == 0))
                do_reset();
            else
                tick();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
